// File: rtl/mem_access_unit.sv
// Data-memory access unit: takes one load/store op from the ALU stage, runs a
// req/gnt/rvalid bus transaction for it and returns formatted load data to the register file.
package mem_access_unit_pkg;

    localparam int unsigned cXLEN       = 32;
    localparam int unsigned cRegSelBitW = 5;

    typedef struct packed {
        logic                   read;
        logic                   write;
        logic [cXLEN-1:0]       addr;
        logic [cXLEN-1:0]       data;
        logic [2:0]             opType;
        logic [cRegSelBitW-1:0] rdAddr;
    } tMemOp;

    typedef struct packed {
        logic                   dv;
        logic [cRegSelBitW-1:0] addr;
        logic [cXLEN-1:0]       data;
    } tRegOp;

endpackage

module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rstN,
    input  tMemOp            iMemOp,
    output logic             oStall,
    output logic             oDmemReq,
    output logic             oDmemWe,
    output logic [cXLEN-1:0] oDmemAddr,
    output logic [cXLEN-1:0] oDmemWdata,
    output logic [3:0]       oDmemBe,
    input  logic             iDmemGnt,
    input  logic             iDmemRvalid,
    input  logic [cXLEN-1:0] iDmemRdata,
    output tRegOp            oRegOp,
    output logic             oMemErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [cXLEN-1:0]       addr_q, addr_d;
    logic [cXLEN-1:0]       wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic [2:0]             op_type_q, op_type_d;
    logic [cRegSelBitW-1:0] rd_q, rd_d;
    logic [1:0]             lane_q, lane_d;
    tRegOp                  regop_q, regop_d;
    logic                   err_q, err_d;

    logic                   legal_c;
    logic                   load_done_c;
    logic [7:0]             byte_c;
    logic [15:0]            half_c;
    logic [cXLEN-1:0]       load_data_c;

    // Legality of the incoming op: direction, opType code and natural alignment.
    always_comb begin
        legal_c = 1'b1;
        if (iMemOp.read && iMemOp.write) begin
            legal_c = 1'b0;
        end else if (iMemOp.read) begin
            unique case (iMemOp.opType)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
                default:                                legal_c = 1'b0;
            endcase
        end else begin
            unique case (iMemOp.opType)
                3'b000, 3'b001, 3'b010: legal_c = 1'b1;
                default:                legal_c = 1'b0;
            endcase
        end
        if (iMemOp.opType[1:0] == 2'b01 && iMemOp.addr[0]) begin
            legal_c = 1'b0;
        end
        if (iMemOp.opType[1:0] == 2'b10 && iMemOp.addr[1:0] != 2'b00) begin
            legal_c = 1'b0;
        end
    end

    // Load lane selection and sign/zero extension from the latched byte offset.
    always_comb begin
        byte_c = iDmemRdata[{lane_q, 3'b000} +: 8];
        half_c = iDmemRdata[{lane_q[1], 4'b0000} +: 16];
        unique case (op_type_q)
            3'b000:  load_data_c = {{(cXLEN-8){byte_c[7]}}, byte_c};
            3'b100:  load_data_c = {{(cXLEN-8){1'b0}}, byte_c};
            3'b001:  load_data_c = {{(cXLEN-16){half_c[15]}}, half_c};
            3'b101:  load_data_c = {{(cXLEN-16){1'b0}}, half_c};
            default: load_data_c = iDmemRdata;
        endcase
    end

    assign load_done_c = ((state_q == REQ) && !we_q && iDmemGnt && iDmemRvalid) ||
                         ((state_q == WAIT_RD) && iDmemRvalid);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        op_type_d = op_type_q;
        rd_d      = rd_q;
        lane_d    = lane_q;
        regop_d   = regop_q;
        regop_d.dv = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (iMemOp.read || iMemOp.write) begin
                    if (!legal_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = REQ;
                        req_d     = 1'b1;
                        we_d      = iMemOp.write;
                        addr_d    = {iMemOp.addr[cXLEN-1:2], 2'b00};
                        op_type_d = iMemOp.opType;
                        rd_d      = iMemOp.rdAddr;
                        lane_d    = iMemOp.addr[1:0];
                        if (iMemOp.read) begin
                            wdata_d = '0;
                            be_d    = 4'b1111;
                        end else begin
                            unique case (iMemOp.opType[1:0])
                                2'b00: begin
                                    wdata_d = {4{iMemOp.data[7:0]}};
                                    be_d    = 4'b0001 << iMemOp.addr[1:0];
                                end
                                2'b01: begin
                                    wdata_d = {2{iMemOp.data[15:0]}};
                                    be_d    = iMemOp.addr[1] ? 4'b1100 : 4'b0011;
                                end
                                default: begin
                                    wdata_d = iMemOp.data;
                                    be_d    = 4'b1111;
                                end
                            endcase
                        end
                    end
                end
            end
            REQ: begin
                if (iDmemGnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: ;
            default: state_d = IDLE;
        endcase

        // Register index 0 is never written back, but the data path still updates.
        if (load_done_c) begin
            state_d       = IDLE;
            regop_d.dv    = (rd_q != '0);
            regop_d.addr  = rd_q;
            regop_d.data  = load_data_c;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            op_type_q <= '0;
            rd_q      <= '0;
            lane_q    <= '0;
            regop_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            op_type_q <= op_type_d;
            rd_q      <= rd_d;
            lane_q    <= lane_d;
            regop_q   <= regop_d;
            err_q     <= err_d;
        end
    end

    assign oStall     = (state_q != IDLE);
    assign oDmemReq   = req_q;
    assign oDmemWe    = we_q;
    assign oDmemAddr  = addr_q;
    assign oDmemWdata = wdata_q;
    assign oDmemBe    = be_q;
    assign oRegOp     = regop_q;
    assign oMemErr    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        rstN;
    tMemOp       mem_op;
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    tRegOp       reg_op;
    logic        err;

    logic [69:0] bus_obs;
    int          n_checks;
    int          n_errors;

    assign bus_obs = {req, we, addr, wdata, be};

    mem_access_unit dut (
        .clk        (clk),
        .rstN       (rstN),
        .iMemOp     (mem_op),
        .oStall     (stall),
        .oDmemReq   (req),
        .oDmemWe    (we),
        .oDmemAddr  (addr),
        .oDmemWdata (wdata),
        .oDmemBe    (be),
        .iDmemGnt   (gnt),
        .iDmemRvalid(rvalid),
        .iDmemRdata (rdata),
        .oRegOp     (reg_op),
        .oMemErr    (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] t, input logic [4:0] r);
        mem_op.read   = rd;
        mem_op.write  = wr;
        mem_op.addr   = a;
        mem_op.data   = d;
        mem_op.opType = t;
        mem_op.rdAddr = r;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        step();
        step();
        n_checks++;
        if (bus_obs !== 70'd0) begin
            n_errors++;
            $display("FAIL reset_bus: got %h expected 0", bus_obs);
        end
        n_checks++;
        if (reg_op !== '0) begin
            n_errors++;
            $display("FAIL reset_regop: got %h expected 0", reg_op);
        end
        n_checks++;
        if ({err, stall} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_err_stall: got %b expected 00", {err, stall});
        end
        rstN = 1'b1;
        step();
    endtask

    task automatic test_sw();
        set_op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 5'd0);
        step();
        mem_op = '0;
        n_checks++;
        if (bus_obs !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111}) begin
            n_errors++;
            $display("FAIL sw_bus: got %h expected %h", bus_obs,
                     {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111});
        end
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL sw_stall_high: got %b expected 1", stall);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        n_checks++;
        if ({req, stall, reg_op.dv} !== 3'b000) begin
            n_errors++;
            $display("FAIL sw_done: req/stall/dv got %b expected 000", {req, stall, reg_op.dv});
        end
    endtask

    task automatic test_sb_delayed_gnt();
        set_op(1'b0, 1'b1, 32'h103, 32'h000000A5, 3'b000, 5'd0);
        step();
        mem_op = '0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus_obs !== {1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 4'b1000} || stall !== 1'b1) begin
                n_errors++;
                $display("FAIL sb_hold_%0d: got %h stall %b expected %h stall 1", i, bus_obs, stall,
                         {1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 4'b1000});
            end
            step();
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        n_checks++;
        if ({req, stall, reg_op.dv} !== 3'b000) begin
            n_errors++;
            $display("FAIL sb_done: req/stall/dv got %b expected 000", {req, stall, reg_op.dv});
        end
    endtask

    task automatic test_loads();
        logic [31:0] la[4];
        logic [2:0]  lt[4];
        logic [31:0] le[4];
        la = '{32'h202, 32'h202, 32'h202, 32'h200};
        lt = '{3'b000, 3'b100, 3'b101, 3'b001};
        le = '{32'hFFFFFF80, 32'h00000080, 32'h00000080, 32'h00001234};
        for (int k = 0; k < 4; k++) begin
            set_op(1'b1, 1'b0, la[k], 32'h0, lt[k], 5'd5);
            step();
            mem_op = '0;
            n_checks++;
            if (bus_obs !== {1'b1, 1'b0, 32'h200, 32'h0, 4'b1111}) begin
                n_errors++;
                $display("FAIL load%0d_bus: got %h expected %h", k, bus_obs,
                         {1'b1, 1'b0, 32'h200, 32'h0, 4'b1111});
            end
            gnt = 1'b1;
            step();
            gnt = 1'b0;
            n_checks++;
            if ({stall, req} !== 2'b10) begin
                n_errors++;
                $display("FAIL load%0d_wait: stall/req got %b expected 10", k, {stall, req});
            end
            step();
            rvalid = 1'b1;
            rdata  = 32'h00801234;
            step();
            rvalid = 1'b0;
            rdata  = 32'h0;
            n_checks++;
            if (reg_op !== {1'b1, 5'd5, le[k]} || stall !== 1'b0) begin
                n_errors++;
                $display("FAIL load%0d_wb: got %h stall %b expected %h stall 0", k, reg_op, stall,
                         {1'b1, 5'd5, le[k]});
            end
            step();
            n_checks++;
            if (reg_op.dv !== 1'b0) begin
                n_errors++;
                $display("FAIL load%0d_dv_pulse: got %b expected 0", k, reg_op.dv);
            end
        end
    endtask

    task automatic test_errors();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       set_op(1'b1, 1'b0, 32'h301, 32'h0, 3'b010, 5'd3);
                1:       set_op(1'b1, 1'b1, 32'h300, 32'h0, 3'b010, 5'd3);
                default: set_op(1'b1, 1'b0, 32'h300, 32'h0, 3'b011, 5'd3);
            endcase
            step();
            mem_op = '0;
            n_checks++;
            if ({err, req, stall} !== 3'b100) begin
                n_errors++;
                $display("FAIL err%0d_pulse: err/req/stall got %b expected 100", k, {err, req, stall});
            end
            step();
            n_checks++;
            if ({err, req} !== 2'b00) begin
                n_errors++;
                $display("FAIL err%0d_clear: err/req got %b expected 00", k, {err, req});
            end
        end
    endtask

    task automatic test_back_to_back();
        set_op(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 5'd0);
        step();
        mem_op = '0;
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h11223344;
        step();
        gnt    = 1'b0;
        rvalid = 1'b0;
        n_checks++;
        if ({reg_op.dv, stall, req} !== 3'b000 || reg_op.data !== 32'h11223344) begin
            n_errors++;
            $display("FAIL rd0_nowb: dv/stall/req %b data %h expected 000 data 11223344",
                     {reg_op.dv, stall, req}, reg_op.data);
        end
        set_op(1'b1, 1'b0, 32'h404, 32'h0, 3'b010, 5'd7);
        step();
        mem_op = '0;
        n_checks++;
        if (bus_obs !== {1'b1, 1'b0, 32'h404, 32'h0, 4'b1111}) begin
            n_errors++;
            $display("FAIL b2b_accept: got %h expected %h", bus_obs,
                     {1'b1, 1'b0, 32'h404, 32'h0, 4'b1111});
        end
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hCAFEF00D;
        step();
        gnt    = 1'b0;
        rvalid = 1'b0;
        n_checks++;
        if (reg_op !== {1'b1, 5'd7, 32'hCAFEF00D}) begin
            n_errors++;
            $display("FAIL b2b_wb: got %h expected %h", reg_op, {1'b1, 5'd7, 32'hCAFEF00D});
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        set_op(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 5'd9);
        step();
        mem_op = '0;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre_wait: stall got %b expected 1", stall);
        end
        #2 rstN = 1'b0;
        #1;
        n_checks++;
        if (bus_obs !== 70'd0 || reg_op !== '0 || {err, stall} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_async: bus %h regop %h err/stall %b expected all 0",
                     bus_obs, reg_op, {err, stall});
        end
        step();
        rstN = 1'b1;
        step();
        rvalid = 1'b1;
        rdata  = 32'h55667788;
        step();
        rvalid = 1'b0;
        n_checks++;
        if (bus_obs !== 70'd0 || reg_op !== '0 || {err, stall} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_stray_rvalid: bus %h regop %h err/stall %b expected all 0",
                     bus_obs, reg_op, {err, stall});
        end
        step();
    endtask

    initial begin
        clk      = 1'b0;
        rstN     = 1'b0;
        mem_op   = '0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_sw();
        test_sb_delayed_gnt();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
